// File: rtl/speaker_i2s_tx_pkg.sv
// speaker_pkg: shared sample/frame constants and types for the speaker I2S transmitter.
package speaker_pkg;
    localparam int SAMPLE_W = 16;
    localparam int SLOTS = 2 * SAMPLE_W;
    localparam int SLOT_W = $clog2(SLOTS);
    localparam int FRAME_LEN = SLOTS * 16;
    localparam logic [SAMPLE_W-1:0] IDLE_SAMPLE = '0;
    typedef struct packed {
        logic [SAMPLE_W-1:0] left;
        logic [SAMPLE_W-1:0] right;
    } sample_pair_t;
endpackage

// File: rtl/speaker_i2s_tx_if.sv
// speaker_i2s_tx_if: sample input bus plus DAC pins between tone logic and the I2S transmitter.
interface speaker_i2s_tx_if;
    import speaker_pkg::*;
    logic [SAMPLE_W-1:0] audio_left;
    logic [SAMPLE_W-1:0] audio_right;
    logic sample_taken;
    logic audio_mclk;
    logic audio_lrck;
    logic audio_sck;
    logic audio_sdin;
    modport master (
        output audio_left, audio_right,
        input  sample_taken, audio_mclk, audio_lrck, audio_sck, audio_sdin
    );
    modport slave (
        input  audio_left, audio_right,
        output sample_taken, audio_mclk, audio_lrck, audio_sck, audio_sdin
    );
endinterface

// File: rtl/speaker_i2s_tx_clk_gen.sv
// spk_clk_gen: free-running frame counter; mclk/sck/lrck are raw counter bits, so glitch-free.
module spk_clk_gen
    import speaker_pkg::*;
#(
    parameter int MCLK_LOG2 = 1,
    parameter int SCK_LOG2 = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    output logic              mclk,
    output logic              sck,
    output logic              lrck,
    output logic [SLOT_W-1:0] slot,
    output logic              slot_end,
    output logic              frame_end
);
    localparam int CW = SCK_LOG2 + 1 + SLOT_W;
    logic [CW-1:0] cnt;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt <= '0;
        else cnt <= en ? cnt + CW'(1) : '0;
    end
    assign mclk = cnt[MCLK_LOG2];
    assign sck = cnt[SCK_LOG2];
    assign lrck = cnt[CW-1];
    assign slot = cnt[CW-1 -: SLOT_W];
    // last clk of a slot: the next edge is the SCK falling edge that opens the following slot
    assign slot_end = en && (&cnt[SCK_LOG2:0]);
    assign frame_end = en && (&cnt);
endmodule

// File: rtl/speaker_i2s_tx.sv
// speaker_i2s_tx: serializes latched L/R samples to a stereo DAC as MCLK/LRCK/SCK/SDIN.
// Define SPK_LEFT_JUSTIFIED_EN for left-justified framing; default is standard I2S (1-bit delay).
module speaker_i2s_tx
    import speaker_pkg::*;
#(
    parameter int MCLK_LOG2 = 1,
    parameter int SCK_LOG2 = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    speaker_i2s_tx_if.slave audio
);
    localparam int BW = $clog2(SAMPLE_W);
    sample_pair_t hold;
    logic mclk, sck, lrck, slot_end, frame_end, sdin, sdin_next, taken;
    logic [SLOT_W-1:0] slot, nxt;
    logic [BW-1:0] idx;
    spk_clk_gen #(.MCLK_LOG2(MCLK_LOG2), .SCK_LOG2(SCK_LOG2)) u_clk_gen (
        .clk(clk), .rst_n(rst_n), .en(en), .mclk(mclk), .sck(sck), .lrck(lrck),
        .slot(slot), .slot_end(slot_end), .frame_end(frame_end)
    );
    // bit for the slot about to start; at the wrap edge hold still has the old frame
    always_comb begin
        nxt = slot + SLOT_W'(1);
`ifdef SPK_LEFT_JUSTIFIED_EN
        idx = ~nxt[BW-1:0];
        sdin_next = nxt[SLOT_W-1] ? hold.right[idx] :
                    (nxt == '0) ? audio.audio_left[SAMPLE_W-1] : hold.left[idx];
`else
        idx = BW'(-nxt);
        sdin_next = (nxt != '0 && nxt <= SLOT_W'(SAMPLE_W)) ? hold.left[idx] : hold.right[idx];
`endif
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold <= '{left: IDLE_SAMPLE, right: IDLE_SAMPLE};
            sdin <= 1'b0;
            taken <= 1'b0;
        end else begin
            if (frame_end) hold <= '{left: audio.audio_left, right: audio.audio_right};
            sdin <= !en ? 1'b0 : slot_end ? sdin_next : sdin;
            taken <= frame_end;
        end
    end
    assign audio.audio_mclk = mclk;
    assign audio.audio_sck = sck;
    assign audio.audio_lrck = lrck;
    assign audio.audio_sdin = sdin;
    assign audio.sample_taken = taken;
endmodule
